// File: rtl/if_fetch_queue.sv
// Instruction fetch unit with a DEPTH-entry queue of {pc, inst} pairs and redirect/drain handling.
// Optional macro IF_FETCH_BYPASS_EN: forward a response straight to the output when the queue is empty.
module if_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        req_en,
   output logic [31:0] req_pc,
   input  logic        rsp_done,
   input  logic [31:0] rsp_inst,
   input  logic        next_rdy,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        rdy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t        state;
   state_t        state_next;
   logic [31:0]   fpc;
   logic [31:0]   stale_pc;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];
   logic          q_valid;
   logic          accept;
   logic          push;
   logic          pop;

   // A response is accepted only for a live request; redirect and reset discard it.
   assign q_valid = (count != '0);
   assign accept  = (state == REQ) && rsp_done && !redirect_valid && !rst;
   assign pop     = q_valid && next_rdy && !redirect_valid && !rst;
   assign rdy     = (count < DEPTH_C);
   assign req_en  = (state != IDLE) && !rst;
   assign req_pc  = (state == DRAIN) ? stale_pc : fpc;

`ifdef IF_FETCH_BYPASS_EN
   logic bypass;
   // An empty queue forwards the response; it is stored only if downstream stalls.
   assign bypass    = accept && !q_valid;
   assign push      = accept && !(bypass && next_rdy);
   assign out_valid = q_valid || bypass;
   assign out_pc    = q_valid ? pc_mem[rd_ptr]   : fpc;
   assign out_inst  = q_valid ? inst_mem[rd_ptr] : rsp_inst;
`else
   assign push      = accept;
   assign out_valid = q_valid;
   assign out_pc    = pc_mem[rd_ptr];
   assign out_inst  = inst_mem[rd_ptr];
`endif

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (en && rdy && !redirect_valid) state_next = REQ;
         end
         REQ: begin
            if (redirect_valid)
               state_next = rsp_done ? IDLE : DRAIN;
            else if (rsp_done && (!en || count_next == DEPTH_C))
               state_next = IDLE;
         end
         DRAIN: begin
            if (rsp_done) state_next = REQ;
         end
         default: state_next = IDLE;
      endcase
   end

   // Redirect flushes the queue outright; stale_pc keeps the in-flight address visible while draining.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         fpc      <= RESET_PC;
         stale_pc <= RESET_PC;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         state <= state_next;
         if (redirect_valid) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fpc    <= redirect_pc;
            if (state == REQ && !rsp_done) stale_pc <= fpc;
         end else begin
            count <= count_next;
            if (accept) fpc    <= fpc + 32'd4;
            if (push)   wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= fpc;
         inst_mem[wr_ptr] <= rsp_inst;
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a {pc, inst} scoreboard fed by the bench's own fetch-PC model.
module tb_if_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_FETCH_BYPASS_EN
   localparam logic BYPASS = 1'b1;
`else
   localparam logic BYPASS = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        req_en;
   logic [31:0] req_pc;
   logic        rsp_done = 1'b0;
   logic [31:0] rsp_inst = '0;
   logic        next_rdy = 1'b0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        rdy;

   entry_t      sb[$];
   int          errors = 0;
   int          checks = 0;
   int          nreq;
   logic [31:0] expFpc = RESET_PC;
   logic        draining = 1'b0;

   if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .en(en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .req_en(req_en), .req_pc(req_pc),
      .rsp_done(rsp_done), .rsp_inst(rsp_inst),
      .next_rdy(next_rdy),
      .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
      .rdy(rdy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mkInst(input logic [31:0] pc);
      return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkFlag(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Sampled mid-cycle: accepted responses go into the scoreboard, handshakes pop and compare.
   task automatic monitor();
      entry_t e;
      if (rst) begin
         checkFlag("req_en_in_reset", req_en, 1'b0);
         sb.delete();
         expFpc   = RESET_PC;
         draining = 1'b0;
      end else if (redirect_valid) begin
         draining = req_en && !rsp_done;
         sb.delete();
         expFpc = redirect_pc;
      end else begin
         if (req_en && rsp_done) begin
            if (draining) begin
               draining = 1'b0;
            end else begin
               checkOutput("req_pc", req_pc, expFpc);
               sb.push_back('{pc: expFpc, inst: mkInst(expFpc)});
               expFpc = expFpc + 32'd4;
            end
         end
         if (out_valid && next_rdy) begin
            if (sb.size() == 0) begin
               checkFlag("out_valid_unexpected", out_valid, 1'b0);
            end else begin
               e = sb.pop_front();
               checkOutput("out_pc", out_pc, e.pc);
               checkOutput("out_inst", out_inst, e.inst);
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic r, input logic e, input logic rv,
                                input logic [31:0] rpc, input logic rd, input logic nr);
      @(posedge clk);
      #1;
      rst            = r;
      en             = e;
      redirect_valid = rv;
      redirect_pc    = rpc;
      rsp_done       = rd;
      next_rdy       = nr;
      rsp_inst       = draining ? 32'hDEAD_BEEF : mkInst(expFpc);
      @(negedge clk);
      monitor();
   endtask

   initial begin
      $display("[TB] reset state");
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkFlag("reset_out_valid", out_valid, 1'b0);
      checkFlag("reset_rdy", rdy, 1'b1);
      checkFlag("reset_req_en", req_en, 1'b0);

      $display("[TB] back-to-back streaming");
      applyStimulus(0, 1, 0, 0, 1, 1);
      checkFlag("stream_idle_req_en", req_en, 1'b0);
      applyStimulus(0, 1, 0, 0, 1, 1);
      checkFlag("stream_first_latency", out_valid, BYPASS);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 1, 0, 0, 1, 1);
         checkFlag("stream_out_valid", out_valid, 1'b1);
      end
      applyStimulus(0, 0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkFlag("stream_empty", out_valid, 1'b0);
      checkOutput("stream_sb_left", 32'(sb.size()), 32'd0);

      $display("[TB] fill to DEPTH then single refill");
      applyStimulus(0, 1, 1, 32'h0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0, 1, 0);
      checkFlag("full_rdy", rdy, 1'b0);
      checkFlag("full_req_en", req_en, 1'b0);
      applyStimulus(0, 1, 0, 0, 1, 1);
      nreq = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 0, 0, 1, 0);
         if (req_en) nreq++;
      end
      checkOutput("single_refill", 32'(nreq), 32'd1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 1);
      checkFlag("fill_empty", out_valid, 1'b0);
      checkOutput("fill_sb_left", 32'(sb.size()), 32'd0);

      $display("[TB] redirect into drain");
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 0, 1);
      checkOutput("pending_req_pc", req_pc, 32'h0);
      applyStimulus(0, 1, 1, 32'h100, 0, 1);
      applyStimulus(0, 1, 0, 0, 0, 1);
      checkFlag("drain_req_en", req_en, 1'b1);
      checkOutput("drain_req_pc", req_pc, 32'h0);
      applyStimulus(0, 1, 0, 0, 0, 1);
      checkOutput("drain_req_pc_hold", req_pc, 32'h0);
      applyStimulus(0, 1, 0, 0, 1, 1);
      checkFlag("drain_discard", out_valid, 1'b0);
      applyStimulus(0, 1, 0, 0, 0, 1);
      checkOutput("redirect_req_pc", req_pc, 32'h100);
      checkFlag("redirect_no_out", out_valid, 1'b0);
      applyStimulus(0, 1, 0, 0, 1, 1);
      checkFlag("redirect_rsp_out", out_valid, BYPASS);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkFlag("redirect_next_out", out_valid, !BYPASS);

      $display("[TB] redirect with push and pop at count 2");
      applyStimulus(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 1, 0);
      checkFlag("two_entries", out_valid, 1'b1);
      applyStimulus(0, 1, 1, 32'h200, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkFlag("flush_out_valid", out_valid, 1'b0);
      checkFlag("flush_rdy", rdy, 1'b1);
      applyStimulus(0, 1, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 1, 1);
      checkOutput("flush_new_pc", req_pc, 32'h200);
      applyStimulus(0, 0, 0, 0, 0, 1);

      $display("[TB] reset during outstanding request");
      applyStimulus(1, 1, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkFlag("midreset_out_valid", out_valid, 1'b0);
      checkFlag("midreset_rdy", rdy, 1'b1);
      checkFlag("midreset_req_en", req_en, 1'b0);
      applyStimulus(0, 1, 0, 0, 1, 1);
      applyStimulus(0, 1, 0, 0, 1, 1);
      checkOutput("midreset_pc", req_pc, RESET_PC);

      $display("[TB] fetch PC wrap");
      applyStimulus(0, 1, 1, 32'hFFFF_FFFC, 1, 1);
      applyStimulus(0, 1, 0, 0, 1, 1);
      applyStimulus(0, 1, 0, 0, 1, 1);
      checkOutput("wrap_top_pc", req_pc, 32'hFFFF_FFFC);
      applyStimulus(0, 1, 0, 0, 1, 1);
      checkOutput("wrap_zero_pc", req_pc, 32'h0000_0000);
      applyStimulus(0, 0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("wrap_sb_left", 32'(sb.size()), 32'd0);

      $display("[TB] push and pop at count DEPTH-1");
      applyStimulus(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0, 1, 1);
      applyStimulus(0, 1, 0, 0, 1, 0);
      checkFlag("nearfull_rdy", rdy, 1'b1);
      checkFlag("nearfull_req_en", req_en, 1'b1);
      applyStimulus(0, 1, 0, 0, 1, 0);
      checkFlag("nowfull_rdy", rdy, 1'b0);
      checkFlag("nowfull_req_en", req_en, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 1);
      checkFlag("final_empty", out_valid, 1'b0);
      checkOutput("final_sb_left", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
